// File: rtl/mp_add_sequencer.sv
// Multi-precision adder: adds two WIDTH*WORDS-bit operands one WIDTH-bit slice per cycle, LSB first.
// Optional subtract mode (iSub) is compiled in with `define MP_ADD_SEQUENCER_SUB_EN.
module mp_add_sequencer #(
  parameter int WIDTH = 32,
  parameter int WORDS = 4
) (
  input  logic                   iClk,
  input  logic                   iRst_n,
  input  logic                   iStart,
  output logic                   oReady,
  input  logic [WIDTH*WORDS-1:0] iA,
  input  logic [WIDTH*WORDS-1:0] iB,
  input  logic                   iC,
`ifdef MP_ADD_SEQUENCER_SUB_EN
  input  logic                   iSub,
`endif
  output logic [WIDTH*WORDS-1:0] oS,
  output logic                   oC,
  output logic                   oBusy,
  output logic                   oDone,
  output logic [1:0]             dbg_state
);

  localparam int TOT = WIDTH * WORDS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  logic [TOT-1:0] op_a;
  logic [TOT-1:0] op_b;
  logic [TOT-1:0] stage;
  logic [TOT-1:0] stage_next;
  logic           carry;
  logic [3:0]     idx;
  logic [WIDTH:0] slice_sum;
  logic           sub_in;

`ifdef MP_ADD_SEQUENCER_SUB_EN
  assign sub_in = iSub;
`else
  assign sub_in = 1'b0;
`endif

  // Handshake: a request is taken on any rising edge where oReady and iStart are both 1;
  // iStart at any other time is dropped, and oDone pulses for one cycle when oS/oC become valid.
  assign oReady    = (state == IDLE);
  assign oBusy     = (state != IDLE);
  assign dbg_state = state;

  always_comb begin
    slice_sum  = {1'b0, op_a[int'(idx)*WIDTH +: WIDTH]}
               + {1'b0, op_b[int'(idx)*WIDTH +: WIDTH]}
               + {{WIDTH{1'b0}}, carry};
    stage_next = stage;
    stage_next[int'(idx)*WIDTH +: WIDTH] = slice_sum[WIDTH-1:0];
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state <= IDLE;
      idx   <= '0;
      carry <= 1'b0;
      stage <= '0;
      op_a  <= '0;
      op_b  <= '0;
      oS    <= '0;
      oC    <= 1'b0;
      oDone <= 1'b0;
    end else begin
      oDone <= 1'b0;
      case (state)
        IDLE: begin
          if (iStart) begin
            // Subtraction is a + ~b + 1, so the inverted operand and forced carry are latched here.
            op_a  <= iA;
            op_b  <= sub_in ? ~iB : iB;
            carry <= sub_in ? 1'b1 : iC;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          stage <= stage_next;
          carry <= slice_sum[WIDTH];
          idx   <= idx + 4'd1;
          if (idx == 4'(WORDS - 1)) begin
            oS    <= stage_next;
            oC    <= slice_sum[WIDTH];
            oDone <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mp_add_sequencer.sv
// Bench for mp_add_sequencer: a WORDS=4 and a WORDS=1 instance against a wide-arithmetic reference model.
module tb_mp_add_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic         rst4_n, start4, c4, sub4;
  logic [127:0] a4, b4;
  logic [127:0] os4;
  logic         oc4, ready4, busy4, done4;
  logic [1:0]   st4;

  logic         rst1_n, start1, c1, sub1;
  logic [31:0]  a1, b1;
  logic [31:0]  os1;
  logic         oc1, ready1, busy1, done1;
  logic [1:0]   st1;

  logic [128:0] exp_q[$];

  mp_add_sequencer #(.WIDTH(32), .WORDS(4)) dut4 (
    .iClk(clk), .iRst_n(rst4_n), .iStart(start4), .oReady(ready4),
    .iA(a4), .iB(b4), .iC(c4),
`ifdef MP_ADD_SEQUENCER_SUB_EN
    .iSub(sub4),
`endif
    .oS(os4), .oC(oc4), .oBusy(busy4), .oDone(done4), .dbg_state(st4)
  );

  mp_add_sequencer #(.WIDTH(32), .WORDS(1)) dut1 (
    .iClk(clk), .iRst_n(rst1_n), .iStart(start1), .oReady(ready1),
    .iA(a1), .iB(b1), .iC(c1),
`ifdef MP_ADD_SEQUENCER_SUB_EN
    .iSub(sub1),
`endif
    .oS(os1), .oC(oc1), .oBusy(busy1), .oDone(done1), .dbg_state(st1)
  );

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "timeout");
  end

  // Reference model: exact wide sum, or difference with carry meaning "no borrow".
  function automatic logic [128:0] gold4(input logic [127:0] a, input logic [127:0] b,
                                         input logic c, input logic s);
    logic [128:0] d;
    if (s) begin
      d = {1'b0, a} - {1'b0, b};
      return {~d[128], d[127:0]};
    end
    return {1'b0, a} + {1'b0, b} + {128'd0, c};
  endfunction

  function automatic logic [32:0] gold1(input logic [31:0] a, input logic [31:0] b,
                                        input logic c, input logic s);
    logic [32:0] d;
    if (s) begin
      d = {1'b0, a} - {1'b0, b};
      return {~d[32], d[31:0]};
    end
    return {1'b0, a} + {1'b0, b} + {32'd0, c};
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Driver: one operation on the WORDS=4 instance; operands are scrambled right after acceptance.
  task automatic op4(input logic [127:0] a, input logic [127:0] b, input logic c, input logic s,
                     output logic [128:0] res, output int lat, output logic [128:0] held,
                     output logic extra_done);
    int guard;
    @(negedge clk);
    guard = 0;
    while (!ready4 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    a4 = a; b4 = b; c4 = c; sub4 = s; start4 = 1'b1;
    @(posedge clk);
    #1;
    start4 = 1'b0;
    a4 = rand128(); b4 = rand128(); c4 = ~c; sub4 = ~s;
    lat = -1;
    res = '0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (done4) begin
        lat = i;
        res = {oc4, os4};
        break;
      end
    end
    @(posedge clk);
    #1;
    held = {oc4, os4};
    extra_done = done4;
  endtask

  task automatic op1(input logic [31:0] a, input logic [31:0] b, input logic c, input logic s,
                     output logic [32:0] res, output int lat, output logic [32:0] held,
                     output logic extra_done);
    int guard;
    @(negedge clk);
    guard = 0;
    while (!ready1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    a1 = a; b1 = b; c1 = c; sub1 = s; start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    a1 = $urandom; b1 = $urandom; c1 = ~c; sub1 = ~s;
    lat = -1;
    res = '0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (done1) begin
        lat = i;
        res = {oc1, os1};
        break;
      end
    end
    @(posedge clk);
    #1;
    held = {oc1, os1};
    extra_done = done1;
  endtask

  task automatic test_reset();
    rst4_n = 1'b0; rst1_n = 1'b0; start4 = 1'b1; start1 = 1'b1;
    a4 = rand128(); b4 = rand128(); c4 = 1'b1;
    a1 = $urandom; b1 = $urandom; c1 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (ready4 !== 1'b1) $display("FAIL reset_ready4: got %b expected 1", ready4); else n_pass++;
    n_checks++; if (busy4 !== 1'b0) $display("FAIL reset_busy4: got %b expected 0", busy4); else n_pass++;
    n_checks++; if (done4 !== 1'b0) $display("FAIL reset_done4: got %b expected 0", done4); else n_pass++;
    n_checks++; if ({oc4, os4} !== 129'd0) $display("FAIL reset_result4: got %h expected 0", {oc4, os4}); else n_pass++;
    n_checks++; if (st4 !== 2'd0) $display("FAIL reset_state4: got %0d expected 0", st4); else n_pass++;
    n_checks++; if ({ready1, busy1, st1} !== 4'b1000) $display("FAIL reset_status1: got %b expected 1000", {ready1, busy1, st1}); else n_pass++;
    @(negedge clk);
    start4 = 1'b0; start1 = 1'b0; rst4_n = 1'b1; rst1_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++; if ({ready4, busy4} !== 2'b10) $display("FAIL post_reset_idle4: got %b expected 10", {ready4, busy4}); else n_pass++;
  endtask

  task automatic test_ripple();
    logic [128:0] res, held; int lat; logic xd;
    op4({128{1'b1}}, 128'd1, 1'b0, 1'b0, res, lat, held, xd);
    n_checks++; if (res !== {1'b1, 128'd0}) $display("FAIL ripple_result: got %h expected %h", res, {1'b1, 128'd0}); else n_pass++;
    n_checks++; if (lat !== 4) $display("FAIL ripple_latency: got %0d expected 4", lat); else n_pass++;
    n_checks++; if (held !== {1'b1, 128'd0}) $display("FAIL ripple_hold: got %h expected %h", held, {1'b1, 128'd0}); else n_pass++;
    n_checks++; if (xd !== 1'b0) $display("FAIL ripple_done_pulse: got %b expected 0", xd); else n_pass++;
  endtask

  task automatic test_carry_in();
    logic [128:0] res, held; int lat; logic xd;
    op4(128'd0, 128'd0, 1'b1, 1'b0, res, lat, held, xd);
    n_checks++; if (res !== 129'd1) $display("FAIL carry_in_result: got %h expected 1", res); else n_pass++;
    n_checks++; if (lat !== 4) $display("FAIL carry_in_latency: got %0d expected 4", lat); else n_pass++;
  endtask

`ifdef MP_ADD_SEQUENCER_SUB_EN
  task automatic test_sub();
    logic [128:0] res, held; int lat; logic xd;
    op4(128'd5, 128'd7, 1'b1, 1'b1, res, lat, held, xd);
    n_checks++; if (res !== {1'b0, {127{1'b1}}, 1'b0}) $display("FAIL sub_borrow: got %h expected %h", res, {1'b0, {127{1'b1}}, 1'b0}); else n_pass++;
    op4(128'd7, 128'd5, 1'b0, 1'b1, res, lat, held, xd);
    n_checks++; if (res !== {1'b1, 128'd2}) $display("FAIL sub_no_borrow: got %h expected %h", res, {1'b1, 128'd2}); else n_pass++;
  endtask
`endif

  // iStart held for 12 cycles with fresh operands each cycle: acceptances land at cycles 0 and 6.
  task automatic test_busy_reject();
    logic [128:0] exp, got;
    logic         exp_busy, exp_done;
    int           n_done;
    exp_q.delete();
    n_done = 0;
    @(negedge clk);
    for (int g = 0; g < 20 && !ready4; g++) @(negedge clk);
    for (int t = 0; t < 20; t++) begin
      if (t < 12) begin
        a4 = rand128(); b4 = rand128(); c4 = 1'($urandom_range(0, 1)); sub4 = 1'b0; start4 = 1'b1;
        if (t == 0 || t == 6) exp_q.push_back(gold4(a4, b4, c4, 1'b0));
      end else begin
        start4 = 1'b0;
      end
      @(posedge clk);
      #1;
      exp_busy = (t < 11) && ((t % 6) != 5);
      exp_done = (t == 4) || (t == 10);
      n_checks++; if (busy4 !== exp_busy) $display("FAIL busy_reject_busy t=%0d: got %b expected %b", t, busy4, exp_busy); else n_pass++;
      n_checks++; if (done4 !== exp_done) $display("FAIL busy_reject_done t=%0d: got %b expected %b", t, done4, exp_done); else n_pass++;
      if (done4) begin
        n_done++;
        got = {oc4, os4};
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 129'd0;
        n_checks++; if (got !== exp) $display("FAIL busy_reject_result t=%0d: got %h expected %h", t, got, exp); else n_pass++;
      end
      @(negedge clk);
    end
    start4 = 1'b0;
    n_checks++; if (n_done !== 2) $display("FAIL busy_reject_count: got %0d expected 2", n_done); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [128:0] res, held; int lat; logic xd;
    int           n_done;
    op4(128'd1, 128'd2, 1'b0, 1'b0, res, lat, held, xd);
    n_checks++; if (res !== 129'd3) $display("FAIL reset_mid_setup: got %h expected 3", res); else n_pass++;
    @(negedge clk);
    a4 = rand128(); b4 = rand128(); c4 = 1'b1; sub4 = 1'b0; start4 = 1'b1;
    @(posedge clk);
    #1;
    start4 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst4_n = 1'b0;
    @(posedge clk);
    #1;
    n_checks++; if ({oc4, os4} !== 129'd0) $display("FAIL reset_mid_result: got %h expected 0", {oc4, os4}); else n_pass++;
    n_checks++; if ({ready4, busy4, done4} !== 3'b100) $display("FAIL reset_mid_status: got %b expected 100", {ready4, busy4, done4}); else n_pass++;
    @(negedge clk);
    rst4_n = 1'b1;
    n_done = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (done4) n_done++;
    end
    n_checks++; if (n_done !== 0) $display("FAIL reset_mid_no_done: got %0d pulses expected 0", n_done); else n_pass++;
  endtask

  task automatic test_random();
    fork
      begin
        logic [127:0] a, b; logic c, s; logic [128:0] res, held, exp; int lat; logic xd;
        for (int n = 0; n < 5000; n++) begin
          case ($urandom_range(0, 3))
            0: begin a = {128{1'b1}}; b = {96'd0, $urandom}; end
            1: begin a = rand128(); b = ~a; end
            default: begin a = rand128(); b = rand128(); end
          endcase
          c = 1'($urandom_range(0, 1));
          s = 1'b0;
`ifdef MP_ADD_SEQUENCER_SUB_EN
          s = 1'($urandom_range(0, 1));
`endif
          exp = gold4(a, b, c, s);
          op4(a, b, c, s, res, lat, held, xd);
          n_checks++; if (res !== exp) $display("FAIL rand4_result n=%0d: got %h expected %h", n, res, exp); else n_pass++;
          n_checks++; if (lat !== 4) $display("FAIL rand4_latency n=%0d: got %0d expected 4", n, lat); else n_pass++;
          n_checks++; if (held !== exp) $display("FAIL rand4_hold n=%0d: got %h expected %h", n, held, exp); else n_pass++;
          n_checks++; if (xd !== 1'b0) $display("FAIL rand4_pulse n=%0d: got %b expected 0", n, xd); else n_pass++;
        end
      end
      begin
        logic [31:0] a, b; logic c, s; logic [32:0] res, held, exp; int lat; logic xd;
        for (int n = 0; n < 5000; n++) begin
          a = ($urandom_range(0, 3) == 0) ? 32'hffff_ffff : $urandom;
          b = $urandom;
          c = 1'($urandom_range(0, 1));
          s = 1'b0;
`ifdef MP_ADD_SEQUENCER_SUB_EN
          s = 1'($urandom_range(0, 1));
`endif
          exp = gold1(a, b, c, s);
          op1(a, b, c, s, res, lat, held, xd);
          n_checks++; if (res !== exp) $display("FAIL rand1_result n=%0d: got %h expected %h", n, res, exp); else n_pass++;
          n_checks++; if (lat !== 1) $display("FAIL rand1_latency n=%0d: got %0d expected 1", n, lat); else n_pass++;
          n_checks++; if (held !== exp) $display("FAIL rand1_hold n=%0d: got %h expected %h", n, held, exp); else n_pass++;
          n_checks++; if (xd !== 1'b0) $display("FAIL rand1_pulse n=%0d: got %b expected 0", n, xd); else n_pass++;
        end
      end
    join
  endtask

  initial begin
    rst4_n = 1'b0; start4 = 1'b0; a4 = '0; b4 = '0; c4 = 1'b0; sub4 = 1'b0;
    rst1_n = 1'b0; start1 = 1'b0; a1 = '0; b1 = '0; c1 = 1'b0; sub1 = 1'b0;
    test_reset();
    test_ripple();
    test_carry_in();
`ifdef MP_ADD_SEQUENCER_SUB_EN
    test_sub();
`endif
    test_busy_reject();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
